// File: rtl/ntt_stage_sequencer_if.sv
// Control bundle between the NTT stage sequencer and the datapath that consumes
// its read/write addresses.
interface ntt_stage_sequencer_if #(
    parameter int unsigned LOGN = 3
);
    localparam int unsigned SW = ($clog2(LOGN) > 1) ? $clog2(LOGN) : 1;

    logic            start;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN-2:0] tw_addr;
    logic [SW-1:0]   stage_idx;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;
    logic            busy;
    logic            done;

    modport master (
        input  start,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr, stage_idx,
        output wr_en, wr_addr_a, wr_addr_b, busy, done
    );

    modport slave (
        output start,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr, stage_idx,
        input  wr_en, wr_addr_a, wr_addr_b, busy, done
    );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF NTT: issues read and twiddle
// addresses one butterfly per cycle and replays them LAT cycles later as write-backs.
module ntt_stage_sequencer #(
    parameter int unsigned LOGN = 3,
    parameter int unsigned LAT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ntt_stage_sequencer_if.master bus
);
    localparam int unsigned SW = ($clog2(LOGN) > 1) ? $clog2(LOGN) : 1;
    localparam int unsigned CW = ($clog2(LAT) > 1) ? $clog2(LAT) : 1;
    localparam int unsigned JW = LOGN - 1;

    localparam logic [JW-1:0]   J_LAST   = '1;
    localparam logic [JW-1:0]   J_ONE    = JW'(1);
    localparam logic [SW-1:0]   S_LAST   = SW'(LOGN - 1);
    localparam logic [SW-1:0]   S_ONE    = SW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LAT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [LOGN-1:0] A_ONE    = LOGN'(1);
    localparam logic [JW-1:0]   TW_ONE   = JW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    // Upper address: butterfly index j with a zero bit inserted at position LOGN-1-s.
    function automatic logic [LOGN-1:0] f_addr_a(input logic [JW-1:0] j, input logic [SW-1:0] s);
        int unsigned     b;
        logic [LOGN-1:0] j_ext;
        logic [LOGN-1:0] mask;
        b     = LOGN - 1 - 32'(s);
        j_ext = {1'b0, j};
        mask  = (A_ONE << b) - A_ONE;
        return ((j_ext & ~mask) << 1) | (j_ext & mask);
    endfunction

    function automatic logic [LOGN-1:0] f_span(input logic [SW-1:0] s);
        return A_ONE << (LOGN - 1 - 32'(s));
    endfunction

    function automatic logic [JW-1:0] f_tw(input logic [JW-1:0] j, input logic [SW-1:0] s);
        logic [JW-1:0] mask;
        mask = (TW_ONE << (LOGN - 1 - 32'(s))) - TW_ONE;
        return (j & mask) << s;
    endfunction

    state_e          r_state, w_state_d;
    logic [SW-1:0]   r_s, w_s_d;
    logic [JW-1:0]   r_j, w_j_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;

    logic            r_rd_en, w_rd_en_d;
    logic [LOGN-1:0] r_rd_addr_a, w_rd_addr_a_d;
    logic [LOGN-1:0] r_rd_addr_b, w_rd_addr_b_d;
    logic [JW-1:0]   r_tw_addr, w_tw_addr_d;
    logic [SW-1:0]   r_stage_idx, w_stage_idx_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;

    logic            r_dl_en [LAT];
    logic [LOGN-1:0] r_dl_a  [LAT];
    logic [LOGN-1:0] r_dl_b  [LAT];

    always_comb begin
        w_state_d = r_state;
        w_s_d     = r_s;
        w_j_d     = r_j;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = StRun;
                    w_s_d     = '0;
                    w_j_d     = '0;
                end
            end
            StRun: begin
                if (r_j == J_LAST) begin
                    w_state_d = StDrain;
                    w_cnt_d   = '0;
                end else begin
                    w_j_d = r_j + J_ONE;
                end
            end
            StDrain: begin
                if (r_cnt == CNT_LAST) begin
                    if (r_s == S_LAST) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StRun;
                        w_s_d     = r_s + S_ONE;
                        w_j_d     = '0;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next state so every port comes straight from a flop.
    always_comb begin
        w_rd_en_d     = (w_state_d == StRun);
        w_busy_d      = (w_state_d == StRun) || (w_state_d == StDrain);
        w_done_d      = (w_state_d == StDone);
        w_stage_idx_d = w_busy_d ? w_s_d : '0;
        w_rd_addr_a_d = r_rd_addr_a;
        w_rd_addr_b_d = r_rd_addr_b;
        w_tw_addr_d   = r_tw_addr;
        if (w_rd_en_d) begin
            w_rd_addr_a_d = f_addr_a(w_j_d, w_s_d);
            w_rd_addr_b_d = f_addr_a(w_j_d, w_s_d) | f_span(w_s_d);
            w_tw_addr_d   = f_tw(w_j_d, w_s_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_s         <= '0;
            r_j         <= '0;
            r_cnt       <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
            r_stage_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_s         <= w_s_d;
            r_j         <= w_j_d;
            r_cnt       <= w_cnt_d;
            r_rd_en     <= w_rd_en_d;
            r_rd_addr_a <= w_rd_addr_a_d;
            r_rd_addr_b <= w_rd_addr_b_d;
            r_tw_addr   <= w_tw_addr_d;
            r_stage_idx <= w_stage_idx_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    // Write-back delay line; cleared on reset so no stale write survives an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LAT); i++) begin
                r_dl_en[i] <= 1'b0;
                r_dl_a[i]  <= '0;
                r_dl_b[i]  <= '0;
            end
        end else begin
            r_dl_en[0] <= r_rd_en;
            r_dl_a[0]  <= r_rd_addr_a;
            r_dl_b[0]  <= r_rd_addr_b;
            for (int i = 1; i < int'(LAT); i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.tw_addr   = r_tw_addr;
    assign bus.stage_idx = r_stage_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wr_en     = r_dl_en[LAT-1];
    assign bus.wr_addr_a = r_dl_a[LAT-1];
    assign bus.wr_addr_b = r_dl_b[LAT-1];
endmodule
